// File: rtl/tl_ram_responder_pkg.sv
// Shared TL-UL constants, field widths and the response record for the RAM responder.
// Imported by the interface, the storage array and the top level.
package tl_ram_responder_pkg;

    localparam int OPCODE_W = 3;
    localparam int PARAM_W  = 3;
    localparam int SIZE_W   = 2;
    localparam int SOURCE_W = 7;
    localparam int ADDR_W   = 31;
    localparam int MASK_W   = 8;
    localparam int DATA_W   = 64;

    localparam logic [OPCODE_W-1:0] A_PUT_FULL    = 3'd0;
    localparam logic [OPCODE_W-1:0] A_PUT_PARTIAL = 3'd1;
    localparam logic [OPCODE_W-1:0] A_GET         = 3'd4;

    localparam logic [OPCODE_W-1:0] D_ACCESS_ACK      = 3'd0;
    localparam logic [OPCODE_W-1:0] D_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [SIZE_W-1:0]   size;
        logic [SOURCE_W-1:0] source;
        logic                denied;
        logic [DATA_W-1:0]   data;
    } d_resp_t;

    function automatic logic is_put(input logic [OPCODE_W-1:0] op);
        return (op == A_PUT_FULL) || (op == A_PUT_PARTIAL);
    endfunction

endpackage

// File: rtl/tl_ram_responder_if.sv
// TL-UL A/D channel bundle between a requester (master) and the RAM responder (slave).
interface tl_ram_responder_if;
    import tl_ram_responder_pkg::*;

    logic                auto_in_a_ready;
    logic                auto_in_a_valid;
    logic [OPCODE_W-1:0] auto_in_a_bits_opcode;
    logic [PARAM_W-1:0]  auto_in_a_bits_param;
    logic [SIZE_W-1:0]   auto_in_a_bits_size;
    logic [SOURCE_W-1:0] auto_in_a_bits_source;
    logic [ADDR_W-1:0]   auto_in_a_bits_address;
    logic [MASK_W-1:0]   auto_in_a_bits_mask;
    logic [DATA_W-1:0]   auto_in_a_bits_data;
    logic                auto_in_a_bits_corrupt;
    logic                auto_in_d_ready;
    logic                auto_in_d_valid;
    logic [OPCODE_W-1:0] auto_in_d_bits_opcode;
    logic [SIZE_W-1:0]   auto_in_d_bits_size;
    logic [SOURCE_W-1:0] auto_in_d_bits_source;
    logic                auto_in_d_bits_denied;
    logic [DATA_W-1:0]   auto_in_d_bits_data;

    modport master (
        input  auto_in_a_ready,
        output auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
               auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_address,
               auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt,
        output auto_in_d_ready,
        input  auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_size,
               auto_in_d_bits_source, auto_in_d_bits_denied, auto_in_d_bits_data
    );

    modport slave (
        output auto_in_a_ready,
        input  auto_in_a_valid, auto_in_a_bits_opcode, auto_in_a_bits_param,
               auto_in_a_bits_size, auto_in_a_bits_source, auto_in_a_bits_address,
               auto_in_a_bits_mask, auto_in_a_bits_data, auto_in_a_bits_corrupt,
        input  auto_in_d_ready,
        output auto_in_d_valid, auto_in_d_bits_opcode, auto_in_d_bits_size,
               auto_in_d_bits_source, auto_in_d_bits_denied, auto_in_d_bits_data
    );

endinterface

// File: rtl/tl_ram_byte_array.sv
// Word-addressed storage with per-byte write enables and a combinational read port.
// Each byte lane is its own array so lanes are written independently.
module tl_ram_byte_array
    import tl_ram_responder_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clock,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [MASK_W-1:0]     we,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    genvar gi;
    generate
        for (gi = 0; gi < MASK_W; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            always_ff @(posedge clock) begin
                if (we[gi]) begin
                    lane_mem[addr] <= wdata[gi*8 +: 8];
                end
            end

            assign rdata[gi*8 +: 8] = lane_mem[addr];
        end
    endgenerate

endmodule

// File: rtl/tl_ram_responder.sv
// Single-beat TL-UL RAM responder: one response register, full throughput,
// writes land at the accept edge so a Get on the following cycle sees them.
module tl_ram_responder
    import tl_ram_responder_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR  = 31'h1000_0000,
    parameter int                DEPTH_LOG2 = 5
) (
    input  logic          clock,
    input  logic          reset,
    tl_ram_responder_if.slave tl
);

    localparam int WIN_LSB = DEPTH_LOG2 + 3;

    logic                  a_ready;
    logic                  a_fire;
    logic                  in_range;
    logic                  op_get;
    logic                  op_put;
    logic                  do_write;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [MASK_W-1:0]     byte_we;
    logic [DATA_W-1:0]     rdata;
    d_resp_t               resp;
    d_resp_t               d_resp_reg;
    d_resp_t               d_resp_next;
    logic                  d_valid_reg;
    logic                  d_valid_next;
    logic                  unused_bits;

    // Reset low blocks acceptance so nothing is written while reset is held.
    assign a_ready  = !d_valid_reg | tl.auto_in_d_ready;
    assign a_fire   = tl.auto_in_a_valid & a_ready & reset;
    assign in_range = tl.auto_in_a_bits_address[ADDR_W-1:WIN_LSB] == BASE_ADDR[ADDR_W-1:WIN_LSB];
    assign word_idx = tl.auto_in_a_bits_address[WIN_LSB-1:3];
    assign op_get   = tl.auto_in_a_bits_opcode == A_GET;
    assign op_put   = is_put(tl.auto_in_a_bits_opcode);
    assign do_write = a_fire & op_put & in_range & !tl.auto_in_a_bits_corrupt;
    assign byte_we  = do_write ? tl.auto_in_a_bits_mask : '0;

    assign unused_bits = ^{tl.auto_in_a_bits_param, tl.auto_in_a_bits_address[2:0]};

    tl_ram_byte_array #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clock (clock),
        .addr  (word_idx),
        .we    (byte_we),
        .wdata (tl.auto_in_a_bits_data),
        .rdata (rdata)
    );

    always_comb begin
        resp        = '0;
        resp.size   = tl.auto_in_a_bits_size;
        resp.source = tl.auto_in_a_bits_source;
        resp.opcode = op_put ? D_ACCESS_ACK : D_ACCESS_ACK_DATA;
        resp.denied = !in_range | !(op_get | op_put) | (op_put & tl.auto_in_a_bits_corrupt);
        resp.data   = (op_get & in_range) ? rdata : '0;
    end

    always_comb begin
        d_resp_next  = d_resp_reg;
        d_valid_next = d_valid_reg;
        if (a_fire) begin
            d_valid_next = 1'b1;
            d_resp_next  = resp;
        end else if (tl.auto_in_d_ready) begin
            d_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            d_valid_reg <= 1'b0;
            d_resp_reg  <= '0;
        end else begin
            d_valid_reg <= d_valid_next;
            d_resp_reg  <= d_resp_next;
        end
    end

    assign tl.auto_in_a_ready       = a_ready;
    assign tl.auto_in_d_valid       = d_valid_reg;
    assign tl.auto_in_d_bits_opcode = d_resp_reg.opcode;
    assign tl.auto_in_d_bits_size   = d_resp_reg.size;
    assign tl.auto_in_d_bits_source = d_resp_reg.source;
    assign tl.auto_in_d_bits_denied = d_resp_reg.denied;
    assign tl.auto_in_d_bits_data   = d_resp_reg.data;

endmodule

// File: tb/tb_tl_ram_responder.sv
// Scoreboard bench for tl_ram_responder: expected responses are predicted at accept time
// from a reference memory and compared in order when the D channel fires.
module tb_tl_ram_responder;
    import tl_ram_responder_pkg::*;

    localparam logic [30:0] BASE = 31'h1000_0000;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    tl_ram_responder_if tl ();

    tl_ram_responder #(
        .BASE_ADDR  (BASE),
        .DEPTH_LOG2 (5)
    ) dut (
        .clock (clock),
        .reset (reset),
        .tl    (tl)
    );

    d_resp_t     exp_q [$];
    logic [63:0] model_mem [32];
    int          n_checks = 0;
    int          n_bad    = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic predict(input logic [2:0] op, input logic [30:0] addr, input logic [7:0] mask,
                           input logic [63:0] data, input logic corrupt, input logic [1:0] size,
                           input logic [6:0] src, output d_resp_t r);
        logic [30:0] base_v;
        logic        rng;
        logic        put;
        logic        get;
        int          idx;
        base_v   = BASE;
        rng      = addr[30:8] == base_v[30:8];
        idx      = int'(addr[7:3]);
        put      = (op == 3'd0) || (op == 3'd1);
        get      = (op == 3'd4);
        r.size   = size;
        r.source = src;
        r.opcode = put ? 3'd0 : 3'd1;
        r.denied = !rng || !(put || get) || (put && corrupt);
        r.data   = (get && rng) ? model_mem[idx] : 64'd0;
        if (put && rng && !corrupt) begin
            for (int b = 0; b < 8; b++) begin
                if (mask[b]) model_mem[idx][b*8 +: 8] = data[b*8 +: 8];
            end
        end
    endtask

    task automatic drive_a(input logic [2:0] op, input logic [30:0] addr, input logic [7:0] mask,
                           input logic [63:0] data, input logic corrupt, input logic [1:0] size,
                           input logic [6:0] src);
        tl.auto_in_a_valid        = 1'b1;
        tl.auto_in_a_bits_opcode  = op;
        tl.auto_in_a_bits_param   = 3'($urandom);
        tl.auto_in_a_bits_size    = size;
        tl.auto_in_a_bits_source  = src;
        tl.auto_in_a_bits_address = addr;
        tl.auto_in_a_bits_mask    = mask;
        tl.auto_in_a_bits_data    = data;
        tl.auto_in_a_bits_corrupt = corrupt;
    endtask

    task automatic send(input logic [2:0] op, input logic [30:0] addr, input logic [7:0] mask,
                        input logic [63:0] data, input logic corrupt, input logic [1:0] size,
                        input logic [6:0] src);
        d_resp_t r;
        int      waited;
        waited = 0;
        @(negedge clock);
        drive_a(op, addr, mask, data, corrupt, size, src);
        #1;
        while (!tl.auto_in_a_ready && waited < 20) begin
            @(negedge clock);
            #1;
            waited++;
        end
        if (!tl.auto_in_a_ready) begin
            check_eq("a_ready_timeout", 64'(tl.auto_in_a_ready), 64'd1);
            tl.auto_in_a_valid = 1'b0;
            return;
        end
        predict(op, addr, mask, data, corrupt, size, src, r);
        exp_q.push_back(r);
        @(posedge clock);
        #1;
        tl.auto_in_a_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || tl.auto_in_d_valid) && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check_eq("drain", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: a D beat seen valid&ready just before the edge fires on that edge.
    initial begin
        d_resp_t e;
        forever begin
            @(negedge clock);
            #2;
            if (reset && tl.auto_in_d_valid && tl.auto_in_d_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("resp_unexpected", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    $display("resp src=%h op=%0d den=%0d data=%h", tl.auto_in_d_bits_source,
                             tl.auto_in_d_bits_opcode, tl.auto_in_d_bits_denied, tl.auto_in_d_bits_data);
                    check_eq("d_opcode", 64'(tl.auto_in_d_bits_opcode), 64'(e.opcode));
                    check_eq("d_size",   64'(tl.auto_in_d_bits_size),   64'(e.size));
                    check_eq("d_source", 64'(tl.auto_in_d_bits_source), 64'(e.source));
                    check_eq("d_denied", 64'(tl.auto_in_d_bits_denied), 64'(e.denied));
                    check_eq("d_data",   tl.auto_in_d_bits_data,        e.data);
                end
            end
        end
    end

    initial begin
        d_resp_t r;
        logic [30:0] a;
        logic [2:0]  op;
        tl.auto_in_a_valid = 1'b0;
        tl.auto_in_d_ready = 1'b1;
        drive_a(3'd4, BASE, 8'h00, 64'd0, 1'b0, 2'd3, 7'd0);
        tl.auto_in_a_valid = 1'b0;

        #1;
        check_eq("rst_d_valid", 64'(tl.auto_in_d_valid), 64'd0);
        check_eq("rst_a_ready", 64'(tl.auto_in_a_ready), 64'd1);
        check_eq("rst_d_data",  tl.auto_in_d_bits_data,  64'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < 32; i++) begin
            send(3'd0, BASE + 31'(i * 8), 8'hFF, {$urandom, $urandom}, 1'b0, 2'd3, 7'(i));
        end

        send(3'd0, 31'h1000_0008, 8'hFF, 64'h1122334455667788, 1'b0, 2'd3, 7'h11);
        send(3'd4, 31'h1000_0008, 8'h00, 64'd0,                1'b0, 2'd3, 7'h22);
        send(3'd1, 31'h1000_0008, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0, 2'd2, 7'h33);
        send(3'd4, 31'h1000_0008, 8'hFF, 64'd0,                1'b0, 2'd3, 7'h44);
        send(3'd4, 31'h1000_0100, 8'hFF, 64'd0,                1'b0, 2'd3, 7'h55);
        send(3'd2, 31'h1000_0010, 8'hFF, 64'hDEAD_BEEF_0000_0001, 1'b0, 2'd3, 7'h56);
        send(3'd0, 31'h1000_0210, 8'hFF, 64'hDEAD_BEEF_0000_0002, 1'b0, 2'd3, 7'h57);
        send(3'd0, 31'h1000_0018, 8'hFF, 64'hDEAD_BEEF_0000_0003, 1'b1, 2'd3, 7'h58);
        send(3'd4, 31'h1000_0010, 8'h00, 64'd0,                1'b0, 2'd3, 7'h59);
        send(3'd4, 31'h1000_0018, 8'h00, 64'd0,                1'b0, 2'd3, 7'h5A);
        send(3'd0, 31'h1000_0020, 8'hFF, 64'h0123_4567_89AB_CDEF, 1'b0, 2'd3, 7'h60);
        send(3'd4, 31'h1000_0020, 8'h00, 64'd0,                1'b0, 2'd3, 7'h61);
        wait_idle();

        // Backpressure: hold d_ready low with a request waiting on A.
        tl.auto_in_d_ready = 1'b0;
        send(3'd4, 31'h1000_0008, 8'h00, 64'd0, 1'b0, 2'd3, 7'h70);
        @(negedge clock);
        drive_a(3'd0, 31'h1000_0028, 8'hF0, 64'hCAFE_F00D_1234_5678, 1'b0, 2'd3, 7'h71);
        #1;
        for (int k = 0; k < 3; k++) begin
            check_eq("hold_a_ready", 64'(tl.auto_in_a_ready), 64'd0);
            check_eq("hold_d_valid", 64'(tl.auto_in_d_valid), 64'd1);
            check_eq("hold_d_data",  tl.auto_in_d_bits_data, exp_q[0].data);
            check_eq("hold_d_src",   64'(tl.auto_in_d_bits_source), 64'(exp_q[0].source));
            @(negedge clock);
            #1;
        end
        tl.auto_in_d_ready = 1'b1;
        #0;
        check_eq("release_a_ready", 64'(tl.auto_in_a_ready), 64'd1);
        predict(3'd0, 31'h1000_0028, 8'hF0, 64'hCAFE_F00D_1234_5678, 1'b0, 2'd3, 7'h71, r);
        exp_q.push_back(r);
        @(posedge clock);
        #1;
        tl.auto_in_a_valid = 1'b0;
        send(3'd4, 31'h1000_0028, 8'h00, 64'd0, 1'b0, 2'd3, 7'h72);
        wait_idle();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 4))
                0: op = 3'd0;
                1: op = 3'd1;
                2: op = 3'd2;
                default: op = 3'd4;
            endcase
            a = ($urandom_range(0, 7) == 0) ? BASE + 31'h300 : BASE + 31'($urandom_range(0, 255));
            send(op, a, 8'($urandom), {$urandom, $urandom}, ($urandom_range(0, 5) == 0),
                 2'($urandom), 7'($urandom));
        end
        wait_idle();

        // Reset with a response held on D: it must vanish immediately.
        tl.auto_in_d_ready = 1'b0;
        send(3'd4, 31'h1000_0008, 8'h00, 64'd0, 1'b0, 2'd3, 7'h7E);
        @(negedge clock);
        #3;
        check_eq("pre_rst_d_valid", 64'(tl.auto_in_d_valid), 64'd1);
        reset = 1'b0;
        #1;
        check_eq("mid_rst_d_valid", 64'(tl.auto_in_d_valid), 64'd0);
        check_eq("mid_rst_a_ready", 64'(tl.auto_in_a_ready), 64'd1);
        check_eq("mid_rst_d_data",  tl.auto_in_d_bits_data, 64'd0);
        check_eq("mid_rst_d_src",   64'(tl.auto_in_d_bits_source), 64'd0);
        exp_q.delete();
        drive_a(3'd0, 31'h1000_0030, 8'hFF, 64'h5555_5555_5555_5555, 1'b0, 2'd3, 7'h7F);
        repeat (2) @(negedge clock);
        #1;
        check_eq("rst_ignores_a", 64'(tl.auto_in_d_valid), 64'd0);
        tl.auto_in_a_valid = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check_eq("post_rst_a_ready", 64'(tl.auto_in_a_ready), 64'd1);
        check_eq("post_rst_d_valid", 64'(tl.auto_in_d_valid), 64'd0);
        tl.auto_in_d_ready = 1'b1;

        send(3'd0, 31'h1000_0038, 8'hFF, 64'h0F0F_1E1E_2D2D_3C3C, 1'b0, 2'd3, 7'h01);
        send(3'd4, 31'h1000_0038, 8'h00, 64'd0,                1'b0, 2'd3, 7'h02);
        wait_idle();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/tl_ram_responder.md
TL_RAM_RESPONDER -- requirements
Module: tl_ram_responder

Interface
REQ-001 The module SHALL have these parameters (name, default, meaning), one per line:
- BASE_ADDR, 31'h1000_0000, byte base address of the window; must be 256-byte aligned.
- DEPTH_LOG2, 5, log2 of the number of 64-bit words (32 words, 256 bytes).
REQ-002 The module SHALL have these ports (name, direction, width, meaning), one per line:
- clock  in  1  single clock; all state on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- auto_in_a_ready  out  1  A-channel accept.
- auto_in_a_valid  in  1  A-channel request valid.
- auto_in_a_bits_opcode  in  3  0 PutFull, 1 PutPartial, 4 Get; all other values unsupported.
- auto_in_a_bits_param  in  3  ignored.
- auto_in_a_bits_size  in  2  log2 of bytes, 0..3; single beat only.
- auto_in_a_bits_source  in  7  requester ID, echoed on D.
- auto_in_a_bits_address  in  31  byte address.
- auto_in_a_bits_mask  in  8  byte lanes.
- auto_in_a_bits_data  in  64  write data.
- auto_in_a_bits_corrupt  in  1  write data poisoned.
- auto_in_d_ready  in  1  D-channel accept.
- auto_in_d_valid  out  1  response valid.
- auto_in_d_bits_opcode  out  3  0 AccessAck, 1 AccessAckData.
- auto_in_d_bits_size  out  2  echo of the request size.
- auto_in_d_bits_source  out  7  echo of the request source.
- auto_in_d_bits_denied  out  1  request rejected.
- auto_in_d_bits_data  out  64  read data; 0 when the response is not a successful Get.

Function
REQ-003 The A-channel handshake SHALL be a_fire = a_valid & a_ready, with a_ready = !d_valid | d_ready (single response register, full throughput).
REQ-004 A request accepted in cycle N SHALL present its response with d_valid=1 in cycle N+1.
REQ-005 While d_valid=1 and d_ready=0, all d_bits SHALL be held stable and a_ready SHALL be 0.
REQ-006 In the same cycle that d fires, a new request SHALL be able to fire; d_valid then stays 1 and carries the new response.
REQ-007 A request SHALL be in range iff address[30:8]==BASE_ADDR[30:8]; the word index SHALL be address[7:3].
REQ-008 A Get in range SHALL respond AccessAckData, denied=0, data=the whole 64-bit word as stored at fire time, with the mask ignored for read.
REQ-009 A PutFull/PutPartial in range with corrupt=0 SHALL write the bytes whose mask bit is 1 at the fire edge, and SHALL respond AccessAck, denied=0.
REQ-010 A Put with corrupt=1 SHALL suppress the write and SHALL respond AccessAck, denied=1.
REQ-011 An out-of-range request or an unsupported opcode SHALL perform no write, and SHALL respond denied=1, opcode AccessAckData for Get/unsupported, AccessAck for Put, data=0.
REQ-012 A Get accepted the cycle after a Put to the same word SHALL return the updated data (write-before-read visibility).
REQ-013 Memory contents SHALL be undefined after reset.
REQ-014 No request SHALL be dropped or duplicated: responses SHALL be issued in acceptance order, exactly one per accepted request.

Reset
REQ-015 Asserting reset low SHALL immediately force d_valid=0; the response register fields SHALL reset to 0.
REQ-016 During reset a_ready SHALL be 1; a_valid SHALL be ignored; no writes SHALL occur.
REQ-017 If reset is asserted mid-handshake with a held response, that response SHALL be discarded.

Structure
REQ-018 A shared package SHALL hold the TL-UL A and D opcode constants and the field widths (3/3/2/7/31/8/64).
REQ-019 The storage SHALL be a sub-module tl_ram_byte_array: 2^DEPTH_LOG2 x 64 bits, 8-bit write enables, combinational read.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- PutFull address 0x1000_0008, mask 0xFF, data 0x1122334455667788; then Get at the same address -> AccessAck, then AccessAckData with data 0x1122334455667788, denied=0, source echoed.
- PutPartial mask 0x0F, data 0xAAAAAAAA_BBBBBBBB to the same word; then Get -> 0x11223344BBBBBBBB.
- Get at 0x1000_0100 (out of range) and opcode 2 at an in-range address -> denied=1, data=0, memory unchanged.
- Back-to-back Put/Get with d_ready tied 1 -> one response per cycle, Get returns the new data.
- Hold d_ready=0 for 3 cycles with a_valid=1 -> a_ready=0, d_bits stable; release -> responses in order.
- Assert reset low with d_valid=1 -> d_valid=0 immediately; after release a_ready=1.
